// File: rtl/scan_line_sequencer.sv
// scan_line_sequencer: walks a pin-name ROM and streams each name as a text line
// (4 name bytes, CR, LF) to a byte UART transmitter.
//
// Optional feature macro: SCAN_SKIP_NUL_EN (name bytes equal to 0x00 are skipped,
// with no cycle cost; CR/LF are always sent).
//
// Parameters:
//   COUNT      - number of table entries scanned (1..2**DEPTH)
//   DEPTH      - ROM address / pin index width
//   REPEAT     - lines sent per pin before advancing (>= 1)
//   GAP_CYCLES - idle clocks after each line (0..65535)
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   run        - level: high scans, low stops at the next line boundary
//   mem_addr   - ROM address (equals the pin index)
//   mem_data   - ROM word, valid one clock after mem_addr is sampled
//   tx_data    - registered byte to transmit
//   tx_valid   - registered valid; accepted when tx_valid && tx_ready
//   tx_ready   - transmitter ready
//   pin_sel    - pin currently driven with serial data
//   busy       - high whenever the sequencer is not idle
//   scan_wrap  - one-cycle pulse in the ADVANCE cycle that wraps the index to 0
module scan_line_sequencer #(
  parameter int unsigned COUNT      = 1,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned REPEAT     = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [DEPTH-1:0] mem_addr,
  input  logic [31:0]      mem_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [DEPTH-1:0] pin_sel,
  output logic             busy,
  output logic             scan_wrap
);

`ifdef SCAN_SKIP_NUL_EN
  localparam bit SkipNul = 1'b1;
`else
  localparam bit SkipNul = 1'b0;
`endif

  localparam logic [DEPTH-1:0] LastPin = DEPTH'(COUNT - 1);
  localparam logic [15:0]      LastGap = 16'(GAP_CYCLES - 1);
  localparam logic [2:0]       IdxLf   = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSend,
    StGap,
    StAdvance
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] pin_q, pin_d;
  logic [31:0]      rep_q, rep_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [15:0]      gap_q, gap_d;

  // Byte of the line at position idx: name bytes MSB first, then CR, LF.
  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    byte_at = w[31:24];
      3'd1:    byte_at = w[23:16];
      3'd2:    byte_at = w[15:8];
      3'd3:    byte_at = w[7:0];
      3'd4:    byte_at = 8'h0D;
      default: byte_at = 8'h0A;
    endcase
  endfunction

  // First position >= from that is actually sent; with NUL skipping it hops over
  // zero name bytes combinationally so the stream has no bubbles.
  function automatic logic [2:0] next_sent(input logic [31:0] w, input logic [2:0] from);
    logic [2:0] idx;
    idx = from;
    for (int i = 0; i < 4; i++) begin
      if (SkipNul && (idx < 3'd4) && (byte_at(w, idx) == 8'h00)) idx = idx + 3'd1;
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pin_q   <= '0;
      rep_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      rep_q   <= rep_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    rep_d     = rep_q;
    word_d    = word_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    gap_d     = gap_q;
    scan_wrap = 1'b0;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        // ROM samples mem_addr at the end of this cycle.
        state_d = StLatch;
      end
      StLatch: begin
        word_d  = mem_data;
        idx_d   = next_sent(mem_data, 3'd0);
        data_d  = byte_at(mem_data, idx_d);
        valid_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (valid_q && tx_ready) begin
          if (idx_q == IdxLf) begin
            valid_d = 1'b0;
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? StGap : StAdvance;
          end else begin
            // Preload the next byte so valid stays high across handshakes.
            idx_d  = next_sent(word_q, idx_q + 3'd1);
            data_d = byte_at(word_q, idx_d);
          end
        end
      end
      StGap: begin
        if (gap_q == LastGap) state_d = StAdvance;
        else                  gap_d   = gap_q + 16'd1;
      end
      StAdvance: begin
        if (rep_q < REPEAT - 1) begin
          rep_d = rep_q + 32'd1;
        end else begin
          rep_d = '0;
          if (pin_q == LastPin) begin
            pin_d     = '0;
            scan_wrap = 1'b1;
          end else begin
            pin_d = pin_q + 1'b1;
          end
        end
        state_d = run ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr = pin_q;
  assign pin_sel  = pin_q;
  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_scan_line_sequencer.sv
// Bench for scan_line_sequencer. dut_a: COUNT=3 REPEAT=1 GAP=0 (vector table, random
// stalls and run drops, reset and stop/resume sequences). dut_b: COUNT=3 REPEAT=2
// GAP=5 with run and tx_ready held high. A negedge monitor compares both streams
// against a line-level model of the expected text.
module tb_scan_line_sequencer;

`ifdef SCAN_SKIP_NUL_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run [2];
  logic       rdy [2];
  logic [9:0] addr [2];
  logic [9:0] psel [2];
  logic [31:0] mdata [2];
  logic [7:0] txd [2];
  logic       txv [2];
  logic       bsy [2];
  logic       wrp [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_line_sequencer #(.COUNT(3), .DEPTH(10), .REPEAT(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run[0]), .mem_addr(addr[0]), .mem_data(mdata[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy[0]), .pin_sel(psel[0]),
    .busy(bsy[0]), .scan_wrap(wrp[0])
  );

  scan_line_sequencer #(.COUNT(3), .DEPTH(10), .REPEAT(2), .GAP_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run[1]), .mem_addr(addr[1]), .mem_data(mdata[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]), .pin_sel(psel[1]),
    .busy(bsy[1]), .scan_wrap(wrp[1])
  );

  function automatic logic [31:0] rom_word(input int a);
    case (a)
      0:       return 32'h4141_3238;  // "AA28"
      1:       return 32'h4231_3220;  // "B12 "
      2:       return 32'h4333_0000;  // "C3\0\0"
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) mdata[d] <= rom_word(int'(addr[d]));
  end

  function automatic int rep_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 5;
  endfunction

  // Text line for a pin: name bytes (NULs dropped when skipping), then CR LF.
  function automatic int line_len(input int pin);
    logic [31:0] w;
    int n;
    w = rom_word(pin);
    n = 2;
    for (int i = 0; i < 4; i++) if (!(Skip && w[31-8*i -: 8] == 8'h00)) n++;
    return n;
  endfunction

  function automatic logic [7:0] line_byte(input int pin, input int pos);
    logic [7:0] q[$];
    logic [31:0] w;
    w = rom_word(pin);
    for (int i = 0; i < 4; i++) if (!(Skip && w[31-8*i -: 8] == 8'h00)) q.push_back(w[31-8*i -: 8]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return (pos < q.size()) ? q[pos] : 8'hEE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stream monitor (line-level model) ----------------
  int   pos [2];
  int   lines [2];
  int   idle_n [2];
  bit   prev_stall [2];
  bit   prev_mid [2];
  bit   pend_wrap [2];
  bit   run_low [2];
  logic [7:0] prev_data [2];
  int   mpin;
  bit   exp_wrap;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pos[d] = 0; lines[d] = 0; idle_n[d] = -1;
        prev_stall[d] = 0; prev_mid[d] = 0; pend_wrap[d] = 0; run_low[d] = 0;
      end else begin
        mpin = (lines[d] / rep_of(d)) % 3;
        chk("mem_addr_eq_pin", 32'(addr[d]), 32'(psel[d]));
        if (prev_stall[d]) begin
          chk("stall_valid", 32'(txv[d]), 32'd1);
          chk("stall_data", 32'(txd[d]), 32'(prev_data[d]));
        end
        if (prev_mid[d]) chk("no_bubble", 32'(txv[d]), 32'd1);
        exp_wrap = 1'b0;
        if (!txv[d] && idle_n[d] >= 0) begin
          idle_n[d]++;
          if (!run[d]) run_low[d] = 1;
          if (idle_n[d] == gap_of(d) + 1) exp_wrap = pend_wrap[d];
        end
        chk("scan_wrap", 32'(wrp[d]), 32'(exp_wrap));
        if (txv[d] && idle_n[d] >= 0) begin
          if (!run_low[d]) chk("line_gap", 32'(idle_n[d]), 32'(gap_of(d) + 3));
          idle_n[d] = -1;
        end
        prev_mid[d] = 0;
        if (txv[d] && rdy[d]) begin
          chk("stream_byte", 32'(txd[d]), 32'(line_byte(mpin, pos[d])));
          chk("pin_sel", 32'(psel[d]), 32'(mpin));
          pos[d]++;
          if (pos[d] == line_len(mpin)) begin
            pos[d] = 0;
            lines[d]++;
            pend_wrap[d] = (lines[d] % (rep_of(d) * 3)) == 0;
            idle_n[d] = 0;
            run_low[d] = 0;
          end else begin
            prev_mid[d] = 1;
          end
        end
        prev_stall[d] = txv[d] && !rdy[d];
        prev_data[d] = txd[d];
      end
    end
  end

  // ---------------- directed vectors for dut_a ----------------
  typedef struct {
    logic       run;
    logic       rdy;
    logic       valid;
    logic       chk_data;
    logic [7:0] data;
    logic       busy;
    logic [9:0] pin;
  } vec_t;

  vec_t tbl [13];
  int   n;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 10'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 10'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 10'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 10'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 10'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 10'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h32, 1'b1, 10'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h32, 1'b1, 10'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h38, 1'b1, 10'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h0D, 1'b1, 10'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h0A, 1'b1, 10'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd1};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      run[d] = 1'b0;
      rdy[d] = 1'b1;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 32'(txv[d]), 32'd0);
      chk("reset_data", 32'(txd[d]), 32'd0);
      chk("reset_busy", 32'(bsy[d]), 32'd0);
      chk("reset_pin", 32'(psel[d]), 32'd0);
      chk("reset_wrap", 32'(wrp[d]), 32'd0);
    end
    rst_n = 1'b1;
    run[1] = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run[0] = tbl[i].run;
      rdy[0] = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(txv[0]), 32'(tbl[i].valid));
      if (tbl[i].chk_data) chk($sformatf("vec%0d_data", i), 32'(txd[0]), 32'(tbl[i].data));
      chk($sformatf("vec%0d_busy", i), 32'(bsy[0]), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_pin", i), 32'(psel[0]), 32'(tbl[i].pin));
      step();
    end

    // Random stalls (ready high ~25%) and occasional run drops.
    for (int i = 0; i < 3000; i++) begin
      rdy[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) run[0] = ~run[0];
      step();
    end
    run[0] = 1'b1;
    rdy[0] = 1'b1;

    // Reset mid-line.
    n = 0;
    while (!txv[0] && n < 100) begin step(); n++; end
    chk("wait_valid_before_reset", 32'(txv[0]), 32'd1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(txv[0]), 32'd0);
    chk("async_reset_data", 32'(txd[0]), 32'd0);
    chk("async_reset_busy", 32'(bsy[0]), 32'd0);
    chk("async_reset_pin", 32'(psel[0]), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    while (!txv[0] && n < 20) begin step(); n++; end
    chk("restart_valid", 32'(txv[0]), 32'd1);
    chk("restart_byte", 32'(txd[0]), 32'h41);
    chk("restart_pin", 32'(psel[0]), 32'd0);

    // Drop run during the second byte of pin 1's line.
    n = 0;
    while (!(txv[0] && psel[0] == 10'd1) && n < 50) begin step(); n++; end
    chk("wait_pin1_line", 32'(txv[0] && psel[0] == 10'd1), 32'd1);
    step();
    run[0] = 1'b0;
    n = 0;
    while (bsy[0] && n < 50) begin step(); n++; end
    chk("stop_busy", 32'(bsy[0]), 32'd0);
    chk("stop_pin", 32'(psel[0]), 32'd2);
    repeat (5) step();
    chk("stopped_valid", 32'(txv[0]), 32'd0);
    chk("stopped_busy", 32'(bsy[0]), 32'd0);
    run[0] = 1'b1;
    n = 0;
    while (!txv[0] && n < 20) begin step(); n++; end
    chk("resume_valid", 32'(txv[0]), 32'd1);
    chk("resume_byte", 32'(txd[0]), 32'h43);
    chk("resume_pin", 32'(psel[0]), 32'd2);

    repeat (200) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
